// File: rtl/vga_fb_writer.sv
// -----------------------------------------------------------------------------
// vga_fb_writer
//
// Wishbone slave that writes pixels into the VGA frame buffer through the
// write port (port A) of the 640x480x4-bit block RAM. The VGA display
// controller scans the same RAM out on its read port. Software can write a
// single pixel, or program a rectangle and launch a hardware fill that
// produces one frame-buffer write per clock. Everything runs on wb_clk.
//
// Register map (register select = i_wb_adr[4:2]):
//   0x00 CTRL   bit0 START (write 1 launches a fill, reads 0)
//               bit1 BUSY  (read-only, fill in progress)
//               bit2 DONE  (sticky, write 1 clears)
//               bit3 ERR   (sticky, write 1 clears)
//   0x04 ORIGIN x0 [11:0], y0 [27:16]
//   0x08 SIZE   w  [11:0], h  [27:16]
//   0x0C COLOR  fill colour [3:0]
//   0x10 PIXEL  x [11:0], y [27:16], colour [31:28]; a write draws one pixel
//   other       read 0, writes ignored, still acknowledged
//
// Ports:
//   wb_clk    in   system / Wishbone clock
//   wb_rst    in   asynchronous active-high reset
//   i_wb_adr  in   byte address
//   i_wb_dat  in   write data
//   i_wb_sel  in   byte selects (all accesses are treated as full-word)
//   i_wb_we   in   write enable
//   i_wb_cyc  in   bus cycle
//   i_wb_stb  in   strobe
//   o_wb_rdt  out  registered read data, valid with o_wb_ack
//   o_wb_ack  out  registered acknowledge
//   o_fb_we   out  frame-buffer write strobe
//   o_fb_adr  out  frame-buffer address, y*FB_W + x
//   o_fb_dat  out  pixel value
//   o_busy    out  rectangle fill in progress
// -----------------------------------------------------------------------------
module vga_fb_writer #(
  parameter int FB_W = 640,
  parameter int FB_H = 480
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [5:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_fb_we,
  output logic [18:0] o_fb_adr,
  output logic [3:0]  o_fb_dat,
  output logic        o_busy
);

  localparam int ADR_W = 19;

  // Coordinate limits widened to 13 bits so x0+w / y0+h never wrap.
  localparam logic [12:0]      FB_W13   = 13'(FB_W);
  localparam logic [12:0]      FB_H13   = 13'(FB_H);
  localparam logic [ADR_W-1:0] ROW_STEP = ADR_W'(FB_W);

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_ORIGIN = 3'd1;
  localparam logic [2:0] SEL_SIZE   = 3'd2;
  localparam logic [2:0] SEL_COLOR  = 3'd3;
  localparam logic [2:0] SEL_PIXEL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row start address for a 640-wide frame: y*640 = y*512 + y*128.
  function automatic logic [ADR_W-1:0] row_base(input logic [11:0] y);
    logic [ADR_W-1:0] yy;
    yy = ADR_W'(y);
    return (yy << 9) + (yy << 7);
  endfunction

  // ---------------------------------------------------------------------------
  // Software-visible registers
  // ---------------------------------------------------------------------------
  logic [11:0] x0, y0, w, h;
  logic [3:0]  color;
  logic [11:0] px, py;
  logic [3:0]  pcol;
  logic        done_bit, err_bit;

  // ---------------------------------------------------------------------------
  // Fill engine state
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [11:0]      cx, cy;          // coordinate currently on o_fb_adr
  logic [11:0]      x_first;         // column each row restarts at
  logic [11:0]      x_last, y_last;  // last column / row after clipping
  logic [ADR_W-1:0] rowbase;         // address of (0, cy)

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       req, commit;
  logic [2:0] sel;
  logic       wr_ctrl, wr_origin, wr_size, wr_color, wr_pixel;
  logic       start_req, launch;
  logic       wr_while_busy;
  logic [11:0] new_px, new_py;
  logic [3:0]  new_pc;
  logic        pix_in_range, pix_go, pix_bad;

  assign req    = i_wb_cyc & i_wb_stb;
  assign sel    = i_wb_adr[4:2];
  // A write takes effect in the cycle the acknowledge is presented.
  assign commit = o_wb_ack & req & i_wb_we;

  assign wr_ctrl   = commit && (sel == SEL_CTRL);
  assign wr_origin = commit && (sel == SEL_ORIGIN);
  assign wr_size   = commit && (sel == SEL_SIZE);
  assign wr_color  = commit && (sel == SEL_COLOR);
  assign wr_pixel  = commit && (sel == SEL_PIXEL);

  assign start_req = wr_ctrl & i_wb_dat[0];
  assign launch    = start_req & ~o_busy;

  // Anything that could disturb a running fill is refused and flagged.
  assign wr_while_busy = o_busy & (wr_origin | wr_size | wr_color | wr_pixel | start_req);

  assign new_px = i_wb_dat[11:0];
  assign new_py = i_wb_dat[27:16];
  assign new_pc = i_wb_dat[31:28];

  assign pix_in_range = ({1'b0, new_px} < FB_W13) && ({1'b0, new_py} < FB_H13);
  assign pix_go       = wr_pixel & ~o_busy & pix_in_range;
  assign pix_bad      = wr_pixel & ~o_busy & ~pix_in_range;

  // ---------------------------------------------------------------------------
  // Rectangle clipping: exclusive end coordinates saturate at the frame edge.
  // ---------------------------------------------------------------------------
  logic [12:0] x_sum, y_sum, xe, ye;
  logic        fill_empty;

  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};
  assign xe    = (x_sum > FB_W13) ? FB_W13 : x_sum;
  assign ye    = (y_sum > FB_H13) ? FB_H13 : y_sum;

  assign fill_empty = (w == 12'd0) || (h == 12'd0) ||
                      ({1'b0, x0} >= FB_W13) || ({1'b0, y0} >= FB_H13);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // rd_mux unassigned (which would infer a latch).
    rd_mux = '0;
    case (sel)
      SEL_CTRL:   rd_mux = {28'd0, err_bit, done_bit, o_busy, 1'b0};
      SEL_ORIGIN: rd_mux = {4'd0, y0, 4'd0, x0};
      SEL_SIZE:   rd_mux = {4'd0, h, 4'd0, w};
      SEL_COLOR:  rd_mux = {28'd0, color};
      SEL_PIXEL:  rd_mux = {pcol, py, 4'd0, px};
      default:    rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wishbone handshake: one-cycle registered ack, so back-to-back requests
  // are acknowledged every other cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      o_wb_ack <= ~o_wb_ack & req;
      if (~o_wb_ack & req) begin
        o_wb_rdt <= rd_mux;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and sticky status bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      x0       <= '0;
      y0       <= '0;
      w        <= '0;
      h        <= '0;
      color    <= '0;
      px       <= '0;
      py       <= '0;
      pcol     <= '0;
      done_bit <= 1'b0;
      err_bit  <= 1'b0;
    end else begin
      if (~o_busy) begin
        if (wr_origin) begin
          x0 <= i_wb_dat[11:0];
          y0 <= i_wb_dat[27:16];
        end
        if (wr_size) begin
          w <= i_wb_dat[11:0];
          h <= i_wb_dat[27:16];
        end
        if (wr_color) begin
          color <= i_wb_dat[3:0];
        end
        if (wr_pixel) begin
          px   <= new_px;
          py   <= new_py;
          pcol <= new_pc;
        end
      end

      // Completion of a fill wins over a software clear in the same cycle,
      // so a finished fill is never lost.
      if (state == DONE) begin
        done_bit <= 1'b1;
      end else if (wr_ctrl && i_wb_dat[2]) begin
        done_bit <= 1'b0;
      end

      if (wr_while_busy || pix_bad) begin
        err_bit <= 1'b1;
      end else if (wr_ctrl && i_wb_dat[3]) begin
        err_bit <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fill FSM and frame-buffer port. Outputs are registered: the first fill
  // pixel is presented in the same edge that enters FILL, and each FILL cycle
  // loads the next pixel, so o_fb_we is high for exactly the FILL cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= IDLE;
      o_busy   <= 1'b0;
      o_fb_we  <= 1'b0;
      o_fb_adr <= '0;
      o_fb_dat <= '0;
      cx       <= '0;
      cy       <= '0;
      x_first  <= '0;
      x_last   <= '0;
      y_last   <= '0;
      rowbase  <= '0;
    end else begin
      o_fb_we <= 1'b0;
      case (state)
        // DONE lasts one cycle; it accepts the same requests as IDLE because
        // the engine is already free again.
        IDLE, DONE: begin
          state <= IDLE;
          if (launch) begin
            if (fill_empty) begin
              state <= DONE;
            end else begin
              state    <= FILL;
              o_busy   <= 1'b1;
              x_first  <= x0;
              x_last   <= 12'(xe - 13'd1);
              y_last   <= 12'(ye - 13'd1);
              cx       <= x0;
              cy       <= y0;
              rowbase  <= row_base(y0);
              o_fb_we  <= 1'b1;
              o_fb_adr <= row_base(y0) + ADR_W'(x0);
              // o_fb_dat holds the fill colour for the whole fill, so later
              // COLOR writes cannot change a fill already in flight.
              o_fb_dat <= color;
            end
          end else if (pix_go) begin
            o_fb_we  <= 1'b1;
            o_fb_adr <= row_base(new_py) + ADR_W'(new_px);
            o_fb_dat <= new_pc;
          end
        end

        FILL: begin
          if (cx == x_last) begin
            if (cy == y_last) begin
              state  <= DONE;
              o_busy <= 1'b0;
            end else begin
              cx       <= x_first;
              cy       <= cy + 12'd1;
              rowbase  <= rowbase + ROW_STEP;
              o_fb_we  <= 1'b1;
              o_fb_adr <= rowbase + ROW_STEP + ADR_W'(x_first);
            end
          end else begin
            cx       <= cx + 12'd1;
            o_fb_we  <= 1'b1;
            o_fb_adr <= rowbase + ADR_W'(cx + 12'd1);
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Inputs that carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{i_wb_sel, i_wb_adr[5], i_wb_adr[1:0], i_wb_dat[15:12]};

endmodule

// File: tb/tb_vga_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_writer
//
// Directed bench for vga_fb_writer. A behavioural model predicts, per clock
// cycle, which frame-buffer write must appear and whether the block is busy;
// it works from rectangles and coordinates (nested loops, y*640+x), not from
// the RTL's state machine. A compare process checks the DUT against it every
// cycle, and hand-computed literals pin the expected addresses and status.
// -----------------------------------------------------------------------------
module tb_vga_fb_writer;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [5:0]  i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we  = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_fb_we;
  logic [18:0] o_fb_adr;
  logic [3:0]  o_fb_dat;
  logic        o_busy;

  vga_fb_writer #(.FB_W(640), .FB_H(480)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_stb (i_wb_stb),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_fb_we  (o_fb_we),
    .o_fb_adr (o_fb_adr),
    .o_fb_dat (o_fb_dat),
    .o_busy   (o_busy)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc_n = 0;
  always @(posedge wb_clk) cyc_n++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [22:0] exp_wr [int];   // cycle -> {address, colour}
  int          fill_s  = -1;   // first / last busy cycle of the current fill
  int          fill_e  = -1;
  int          done_at = -1;   // cycle from which DONE reads 1
  logic [11:0] m_x0 = '0, m_y0 = '0, m_w = '0, m_h = '0;
  logic [3:0]  m_col = '0;
  logic [31:0] m_pix = '0;
  bit          m_err = 1'b0;
  bit          model_en = 1'b0;

  function automatic bit m_busy(input int c);
    return (fill_s >= 0) && (c >= fill_s) && (c <= fill_e);
  endfunction

  function automatic bit m_done(input int c);
    return (done_at >= 0) && (c >= done_at);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] s, input int r);
    case (s)
      3'd0:    return {28'd0, m_err, m_done(r), m_busy(r), 1'b0};
      3'd1:    return {4'd0, m_y0, 4'd0, m_x0};
      3'd2:    return {4'd0, m_h, 4'd0, m_w};
      3'd3:    return {28'd0, m_col};
      3'd4:    return m_pix;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    exp_wr.delete();
    fill_s = -1; fill_e = -1; done_at = -1;
    m_x0 = '0; m_y0 = '0; m_w = '0; m_h = '0; m_col = '0; m_pix = '0; m_err = 1'b0;
  endtask

  // Launch a fill whose START write was acknowledged in cycle c.
  task automatic model_launch(input int c);
    int xs, ys, k;
    xs = int'(m_x0) + int'(m_w); if (xs > 640) xs = 640;
    ys = int'(m_y0) + int'(m_h); if (ys > 480) ys = 480;
    if (m_w == 0 || m_h == 0 || m_x0 >= 640 || m_y0 >= 480) begin
      done_at = c + 2;
    end else begin
      k = 0;
      for (int yy = int'(m_y0); yy < ys; yy++)
        for (int xx = int'(m_x0); xx < xs; xx++) begin
          exp_wr[c + 1 + k] = {19'(yy * 640 + xx), m_col};
          k++;
        end
      fill_s  = c + 1;
      fill_e  = c + k;
      done_at = c + k + 2;
    end
  endtask

  // A write acknowledged in cycle c.
  task automatic model_commit(input logic [5:0] a, input logic [31:0] d, input int c);
    bit b;
    int x, y;
    b = m_busy(c);
    case (a[4:2])
      3'd0: begin
        if (d[2] && m_done(c)) done_at = -1;
        if (d[3]) m_err = 1'b0;
        if (d[0]) begin
          if (b) m_err = 1'b1;
          else   model_launch(c);
        end
      end
      3'd1: if (b) m_err = 1'b1; else begin m_x0 = d[11:0]; m_y0 = d[27:16]; end
      3'd2: if (b) m_err = 1'b1; else begin m_w = d[11:0]; m_h = d[27:16]; end
      3'd3: if (b) m_err = 1'b1; else m_col = d[3:0];
      3'd4: begin
        if (b) m_err = 1'b1;
        else begin
          m_pix = d & 32'hFFFF_0FFF;
          x = int'(d[11:0]);
          y = int'(d[27:16]);
          if (x < 640 && y < 480) exp_wr[c + 1] = {19'(y * 640 + x), d[31:28]};
          else m_err = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  int seen_adr[$];
  int seen_dat[$];

  always @(negedge wb_clk) begin
    if (model_en) begin
      if (exp_wr.exists(cyc_n)) begin
        check("fb_we", {31'd0, o_fb_we}, 32'd1);
        check("fb_adr", {13'd0, o_fb_adr}, {13'd0, exp_wr[cyc_n][22:4]});
        check("fb_dat", {28'd0, o_fb_dat}, {28'd0, exp_wr[cyc_n][3:0]});
      end else begin
        check("fb_we_idle", {31'd0, o_fb_we}, 32'd0);
      end
      check("busy", {31'd0, o_busy}, {31'd0, m_busy(cyc_n)});
      if (o_fb_we) begin
        seen_adr.push_back(int'(o_fb_adr));
        seen_dat.push_back(int'(o_fb_dat));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic wb_xfer(input logic [5:0] a, input logic [31:0] d, input logic we,
                         output logic [31:0] rd, output int ack_c);
    int n;
    n = 0;
    i_wb_adr = a; i_wb_dat = d; i_wb_we = we; i_wb_sel = 4'hF;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!o_wb_ack && n < 16);
    ack_c = cyc_n;
    rd    = o_wb_rdt;
    check("ack_latency", 32'(n), 32'd2);
    if (o_wb_ack && we) model_commit(a, d, ack_c);
    @(posedge wb_clk);
    #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int ac;
    wb_xfer(a, d, 1'b1, rd, ac);
  endtask

  task automatic wb_read(input string name, input logic [5:0] a, output logic [31:0] rd);
    int ac;
    wb_xfer(a, 32'd0, 1'b0, rd, ac);
    check(name, rd, m_read(a[4:2], ac - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    int exp_fill[6];
    int exp_clip[2];
    int n, bad;

    exp_fill = '{12810, 12811, 12812, 13450, 13451, 13452};
    exp_clip = '{307198, 307199};

    // Reset state.
    repeat (3) @(negedge wb_clk);
    check("rst_ack",    {31'd0, o_wb_ack}, 32'd0);
    check("rst_rdt",    o_wb_rdt, 32'd0);
    check("rst_fb_we",  {31'd0, o_fb_we}, 32'd0);
    check("rst_fb_adr", {13'd0, o_fb_adr}, 32'd0);
    check("rst_fb_dat", {28'd0, o_fb_dat}, 32'd0);
    check("rst_busy",   {31'd0, o_busy}, 32'd0);
    wb_rst   = 1'b0;
    model_en = 1'b1;
    @(posedge wb_clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      wb_read("rst_read", 6'(i * 4), rd);
      check("rst_read_zero", rd, 32'd0);
    end

    // Single pixel x=5 y=2 colour 0xA.
    wb_write(6'h10, 32'hA002_0005);
    @(negedge wb_clk);
    check("pix_we",  {31'd0, o_fb_we}, 32'd1);
    check("pix_adr", {13'd0, o_fb_adr}, 32'd1285);
    check("pix_dat", {28'd0, o_fb_dat}, 32'hA);
    @(posedge wb_clk);
    #1;
    wb_read("pix_ctrl", 6'h00, rd);
    check("pix_no_err", rd & 32'h8, 32'd0);

    // 3x2 fill at (10,20), colour 0xF.
    wb_write(6'h04, 32'h0014_000A);
    wb_write(6'h08, 32'h0002_0003);
    wb_write(6'h0C, 32'h0000_000F);
    seen_adr.delete();
    wb_write(6'h00, 32'h0000_0001);
    idle(12);
    check("fill_count", 32'(seen_adr.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("fill_adr%0d", i), 32'(seen_adr[i]), 32'(exp_fill[i]));
    wb_read("fill_ctrl", 6'h00, rd);
    check("fill_ctrl_lit", rd, 32'h4);
    wb_write(6'h00, 32'h0000_0004);

    // Clipped fill at the bottom-right corner; START together with DONE clear.
    wb_write(6'h04, 32'h01DF_027E);
    wb_write(6'h08, 32'h0005_0005);
    seen_adr.delete();
    wb_write(6'h00, 32'h0000_0005);
    idle(8);
    check("clip_count", 32'(seen_adr.size()), 32'd2);
    for (int i = 0; i < 2; i++) check($sformatf("clip_adr%0d", i), 32'(seen_adr[i]), 32'(exp_clip[i]));
    wb_read("clip_ctrl", 6'h00, rd);
    check("clip_ctrl_lit", rd, 32'h4);

    // Empty fill (w=0): DONE appears two cycles after the START ack.
    wb_write(6'h08, 32'h0005_0000);
    seen_adr.delete();
    wb_write(6'h00, 32'h0000_0005);
    wb_read("empty_ctrl_early", 6'h00, rd);
    check("empty_ctrl_early_lit", rd, 32'h0);
    wb_read("empty_ctrl", 6'h00, rd);
    check("empty_ctrl_lit", rd, 32'h4);
    check("empty_no_write", 32'(seen_adr.size()), 32'd0);

    // Out-of-range pixel x=640: no write, ERR.
    wb_write(6'h10, 32'h3000_0280);
    idle(3);
    check("oor_no_write", 32'(seen_adr.size()), 32'd0);
    wb_read("oor_ctrl", 6'h00, rd);
    check("oor_ctrl_lit", rd, 32'hC);
    wb_write(6'h00, 32'h0000_000C);

    // COLOR write during a 20x2 fill is refused; fill colour stays 5.
    wb_write(6'h04, 32'h0064_0000);
    wb_write(6'h08, 32'h0002_0014);
    wb_write(6'h0C, 32'h0000_0005);
    seen_adr.delete();
    seen_dat.delete();
    wb_write(6'h00, 32'h0000_0001);
    wb_write(6'h0C, 32'h0000_000C);
    idle(50);
    check("busyw_count", 32'(seen_dat.size()), 32'd40);
    bad = 0;
    foreach (seen_dat[i]) if (seen_dat[i] != 5) bad++;
    check("busyw_colour_kept", 32'(bad), 32'd0);
    wb_read("busyw_ctrl", 6'h00, rd);
    check("busyw_ctrl_lit", rd, 32'hC);
    wb_read("busyw_color", 6'h0C, rd);
    check("busyw_color_lit", rd, 32'h5);
    wb_write(6'h00, 32'h0000_000C);

    // Reset asserted at pixel 40 of a 100-pixel fill.
    wb_write(6'h04, 32'h0000_0000);
    wb_write(6'h08, 32'h0001_0064);
    seen_adr.delete();
    wb_write(6'h00, 32'h0000_0001);
    n = 0;
    while (seen_adr.size() < 40 && n < 200) begin
      @(negedge wb_clk);
      #1;
      n++;
    end
    check("rstfill_reached40", 32'(seen_adr.size()), 32'd40);
    check("rstfill_pre_we", {31'd0, o_fb_we}, 32'd1);
    model_en = 1'b0;
    #1 wb_rst = 1'b1;
    #1;
    check("rstfill_we",   {31'd0, o_fb_we}, 32'd0);
    check("rstfill_busy", {31'd0, o_busy}, 32'd0);
    check("rstfill_adr",  {13'd0, o_fb_adr}, 32'd0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    model_reset();
    seen_adr.delete();
    model_en = 1'b1;
    @(posedge wb_clk);
    #1;
    idle(20);
    check("rstfill_no_write", 32'(seen_adr.size()), 32'd0);
    wb_read("rstfill_ctrl", 6'h00, rd);
    check("rstfill_ctrl_lit", rd, 32'h0);
    wb_read("rstfill_size", 6'h08, rd);
    check("rstfill_size_lit", rd, 32'h0);

    idle(2);
    model_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
